// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported asynchronous SRAM.
// Partial-byte writes go through a read-modify-write sequence.
module ram_arbiter #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [3:0]  a_be,
    input  logic [18:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_rdy,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [3:0]  b_be,
    input  logic [18:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_rdy,
    output logic [31:0] b_rdata,
    output logic        ram_ce_b,
    output logic        ram_oe_b,
    output logic        ram_we_b,
    output logic [18:0] ram_addr,
    output logic [31:0] ram_dout,
    output logic        ram_dout_oe,
    input  logic [31:0] ram_din
);
    typedef enum logic [2:0] {IDLE, READ, RMW_RD, WRITE, DONE} state_t;

    localparam logic [2:0] RD_CNT = 3'(RD_LAT);
    localparam logic [2:0] WR_CNT = 3'(WR_LAT);

    state_t      state_q, state_d;
    logic [2:0]  lcount_q, lcount_d;
    logic        last_b_q, last_b_d;
    logic        sel_b_q, sel_b_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ce_b_q, ce_b_d, oe_b_q, oe_b_d, we_b_q, we_b_d;
    logic        dout_oe_q, dout_oe_d;
    logic [18:0] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic        a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
    logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic        grant_b;
    logic        g_we;
    logic [3:0]  g_be;
    logic [18:0] g_addr;
    logic [31:0] g_wdata;
    logic [31:0] merged;

    // B wins when it is alone, or on a tie when A was served last.
    assign grant_b = b_req && (!a_req || !last_b_q);
    assign g_we    = grant_b ? b_we    : a_we;
    assign g_be    = grant_b ? b_be    : a_be;
    assign g_addr  = grant_b ? b_addr  : a_addr;
    assign g_wdata = grant_b ? b_wdata : a_wdata;

    always_comb begin
        merged = ram_din;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        lcount_d  = lcount_q;
        last_b_d  = last_b_q;
        sel_b_d   = sel_b_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        ce_b_d    = ce_b_q;
        oe_b_d    = oe_b_q;
        we_b_d    = we_b_q;
        dout_oe_d = dout_oe_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        a_rdy_d   = 1'b0;
        b_rdy_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    sel_b_d  = grant_b;
                    last_b_d = grant_b;
                    be_d     = g_be;
                    wdata_d  = g_wdata;
                    addr_d   = g_addr;
                    ce_b_d   = 1'b0;
                    if (g_we && g_be == 4'hF) begin
                        oe_b_d    = 1'b1;
                        we_b_d    = 1'b0;
                        dout_d    = g_wdata;
                        dout_oe_d = 1'b1;
                        lcount_d  = WR_CNT;
                        state_d   = WRITE;
                    end else begin
                        oe_b_d    = 1'b0;
                        we_b_d    = 1'b1;
                        dout_oe_d = 1'b0;
                        lcount_d  = RD_CNT;
                        state_d   = g_we ? RMW_RD : READ;
                    end
                end
            end
            READ: begin
                if (lcount_q != 3'd0) begin
                    lcount_d = lcount_q - 3'd1;
                end else begin
                    if (sel_b_q) b_rdata_d = ram_din;
                    else         a_rdata_d = ram_din;
                    ce_b_d  = 1'b1;
                    oe_b_d  = 1'b1;
                    we_b_d  = 1'b1;
                    a_rdy_d = !sel_b_q;
                    b_rdy_d = sel_b_q;
                    state_d = DONE;
                end
            end
            RMW_RD: begin
                if (lcount_q != 3'd0) begin
                    lcount_d = lcount_q - 3'd1;
                end else begin
                    oe_b_d    = 1'b1;
                    we_b_d    = 1'b0;
                    dout_d    = merged;
                    dout_oe_d = 1'b1;
                    lcount_d  = WR_CNT;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (lcount_q != 3'd0) begin
                    lcount_d = lcount_q - 3'd1;
                end else begin
                    ce_b_d    = 1'b1;
                    oe_b_d    = 1'b1;
                    we_b_d    = 1'b1;
                    dout_oe_d = 1'b0;
                    a_rdy_d   = !sel_b_q;
                    b_rdy_d   = sel_b_q;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            lcount_q  <= 3'd0;
            last_b_q  <= 1'b0;
            sel_b_q   <= 1'b0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            ce_b_q    <= 1'b1;
            oe_b_q    <= 1'b1;
            we_b_q    <= 1'b1;
            dout_oe_q <= 1'b0;
            addr_q    <= 19'h0;
            dout_q    <= 32'h0;
            a_rdy_q   <= 1'b0;
            b_rdy_q   <= 1'b0;
            a_rdata_q <= 32'h0;
            b_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            lcount_q  <= lcount_d;
            last_b_q  <= last_b_d;
            sel_b_q   <= sel_b_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            ce_b_q    <= ce_b_d;
            oe_b_q    <= oe_b_d;
            we_b_q    <= we_b_d;
            dout_oe_q <= dout_oe_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            a_rdy_q   <= a_rdy_d;
            b_rdy_q   <= b_rdy_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign ram_ce_b    = ce_b_q;
    assign ram_oe_b    = oe_b_q;
    assign ram_we_b    = we_b_q;
    assign ram_addr    = addr_q;
    assign ram_dout    = dout_q;
    assign ram_dout_oe = dout_oe_q;
    assign a_rdy       = a_rdy_q;
    assign b_rdy       = b_rdy_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: SRAM model on the bus plus a transaction-level
// reference (expected memory image, per-port read data, round-robin pointer).
module tb_ram_arbiter;
    localparam int RD_LAT = 1;
    localparam int WR_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [3:0]  a_be = 0, b_be = 0;
    logic [18:0] a_addr = 0, b_addr = 0;
    logic [31:0] a_wdata = 0, b_wdata = 0;
    logic        a_rdy, b_rdy;
    logic [31:0] a_rdata, b_rdata;
    logic        ram_ce_b, ram_oe_b, ram_we_b, ram_dout_oe;
    logic [18:0] ram_addr;
    logic [31:0] ram_dout;
    logic [31:0] ram_din = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram [int];
    logic [31:0] refm [int];
    bit          last_b;
    logic [31:0] ref_a_rdata, ref_b_rdata;

    ram_arbiter #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .rst_b(rst_b),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdy(a_rdy), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdy(b_rdy), .b_rdata(b_rdata),
        .ram_ce_b(ram_ce_b), .ram_oe_b(ram_oe_b), .ram_we_b(ram_we_b),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_dout_oe(ram_dout_oe),
        .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] sram_rd(int a);
        if (sram.exists(a)) return sram[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(int a);
        if (refm.exists(a)) return refm[a];
        return dflt(a);
    endfunction

    // Asynchronous SRAM: writes while ce/we are low, read data settles mid-cycle.
    always @(negedge clk) begin
        if (rst_b) begin
            checks++;
            if (!ram_oe_b && ram_dout_oe) begin
                errors++;
                $display("FAIL bus_contention: oe_b=%0b dout_oe=%0b at %0t", ram_oe_b, ram_dout_oe, $time);
            end
        end
        if (!ram_ce_b && !ram_we_b) sram[int'(ram_addr)] = ram_dout;
        ram_din = sram_rd(int'(ram_addr));
    end

    task automatic preload(input int a, input logic [31:0] v);
        sram[a] = v;
        refm[a] = v;
    endtask

    task automatic set_port(input bit pb, input logic req, input logic we, input logic [3:0] be,
                            input logic [18:0] addr, input logic [31:0] wd);
        if (pb) begin
            b_req = req; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
        end
    endtask

    // One complete transaction starting from an idle arbiter; returns 1 cycle after DONE.
    task automatic do_txn(input bit pb, input bit we, input logic [3:0] be, input logic [18:0] addr,
                          input logic [31:0] wd, input bit drop);
        int          lat;
        bit          full;
        logic [31:0] oldv, merged;
        logic        got_rdy, oth_rdy;
        oldv = ref_rd(int'(addr));
        for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : oldv[8*i +: 8];
        full = we && (be == 4'hF);
        lat  = !we ? RD_LAT + 1 : (full ? WR_LAT + 1 : RD_LAT + WR_LAT + 2);
        @(negedge clk);
        set_port(pb, 1'b1, we, be, addr, wd);
        set_port(!pb, 1'b0, 1'b0, 4'h0, 19'h0, 32'h0);
        @(posedge clk); #1;
        last_b = pb;
        checks++;
        if (ram_ce_b !== 1'b0 || ram_addr !== addr) begin
            errors++;
            $display("FAIL grant: ce_b=%0b addr=%05h, expected ce_b=0 addr=%05h", ram_ce_b, ram_addr, addr);
        end
        checks++;
        if (full) begin
            if (ram_we_b !== 1'b0 || ram_oe_b !== 1'b1 || ram_dout_oe !== 1'b1 || ram_dout !== wd) begin
                errors++;
                $display("FAIL write_phase: we_b=%0b oe_b=%0b oe=%0b dout=%08h, expected 0 1 1 %08h",
                         ram_we_b, ram_oe_b, ram_dout_oe, ram_dout, wd);
            end
        end else if (ram_oe_b !== 1'b0 || ram_we_b !== 1'b1 || ram_dout_oe !== 1'b0) begin
            errors++;
            $display("FAIL read_phase: oe_b=%0b we_b=%0b oe=%0b, expected 0 1 0", ram_oe_b, ram_we_b, ram_dout_oe);
        end
        if (drop) set_port(pb, 1'b0, $urandom, 4'($urandom), 19'($urandom), $urandom);
        for (int n = 1; n <= lat; n++) begin
            @(posedge clk); #1;
            got_rdy = pb ? b_rdy : a_rdy;
            oth_rdy = pb ? a_rdy : b_rdy;
            checks++;
            if (got_rdy !== (n == lat) || oth_rdy !== 1'b0) begin
                errors++;
                $display("FAIL rdy_timing: cycle %0d rdy=%0b other=%0b, expected rdy=%0b other=0",
                         n, got_rdy, oth_rdy, n == lat);
            end
            if (n < lat) begin
                checks++;
                if (ram_ce_b !== 1'b0) begin
                    errors++;
                    $display("FAIL ce_hold: cycle %0d ce_b=%0b, expected 0", n, ram_ce_b);
                end
            end
            if (we && !full && n == RD_LAT + 1) begin
                checks++;
                if (ram_we_b !== 1'b0 || ram_oe_b !== 1'b1 || ram_dout_oe !== 1'b1 || ram_dout !== merged) begin
                    errors++;
                    $display("FAIL rmw_write: we_b=%0b oe_b=%0b oe=%0b dout=%08h, expected 0 1 1 %08h",
                             ram_we_b, ram_oe_b, ram_dout_oe, ram_dout, merged);
                end
            end
            if (n == lat) begin
                checks++;
                if (ram_ce_b !== 1'b1 || ram_oe_b !== 1'b1 || ram_we_b !== 1'b1 || ram_dout_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL release: ce_b=%0b oe_b=%0b we_b=%0b oe=%0b, expected 1 1 1 0",
                             ram_ce_b, ram_oe_b, ram_we_b, ram_dout_oe);
                end
                set_port(pb, 1'b0, 1'b0, 4'h0, 19'h0, 32'h0);
            end
        end
        if (!we) begin
            if (pb) ref_b_rdata = oldv;
            else    ref_a_rdata = oldv;
        end else begin
            refm[int'(addr)] = merged;
        end
        checks++;
        if (a_rdata !== ref_a_rdata || b_rdata !== ref_b_rdata) begin
            errors++;
            $display("FAIL rdata: a=%08h b=%08h, expected a=%08h b=%08h", a_rdata, b_rdata, ref_a_rdata, ref_b_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (a_rdy !== 1'b0 || b_rdy !== 1'b0 || ram_ce_b !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle: a_rdy=%0b b_rdy=%0b ce_b=%0b, expected 0 0 1", a_rdy, b_rdy, ram_ce_b);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        last_b = 1'b0;
        ref_a_rdata = 32'h0;
        ref_b_rdata = 32'h0;
        checks++;
        if (ram_ce_b !== 1 || ram_oe_b !== 1 || ram_we_b !== 1 || ram_dout_oe !== 0 ||
            ram_addr !== 19'h0 || ram_dout !== 32'h0 || a_rdy !== 0 || b_rdy !== 0 ||
            a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ce=%0b oe=%0b we=%0b doe=%0b addr=%05h dout=%08h rdy=%0b%0b rd=%08h/%08h, expected 1110 0 0 00 0/0",
                     ram_ce_b, ram_oe_b, ram_we_b, ram_dout_oe, ram_addr, ram_dout, a_rdy, b_rdy, a_rdata, b_rdata);
        end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_round_robin();
        bit          win;
        logic [18:0] exp_addr;
        logic        w_rdy, l_rdy;
        set_port(1'b0, 1'b1, 1'b0, 4'hF, 19'h00100, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 4'hF, 19'h00200, 32'h0);
        for (int g = 0; g < 4; g++) begin
            win = !last_b;
            exp_addr = win ? 19'h00200 : 19'h00100;
            @(posedge clk); #1;
            last_b = win;
            checks++;
            if (ram_ce_b !== 1'b0 || ram_addr !== exp_addr) begin
                errors++;
                $display("FAIL rr_grant: grant %0d ce_b=%0b addr=%05h, expected 0 %05h", g, ram_ce_b, ram_addr, exp_addr);
            end
            for (int n = 1; n <= RD_LAT + 1; n++) begin
                @(posedge clk); #1;
                w_rdy = win ? b_rdy : a_rdy;
                l_rdy = win ? a_rdy : b_rdy;
                checks++;
                if (w_rdy !== (n == RD_LAT + 1) || l_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_rdy: grant %0d cycle %0d rdy=%0b other=%0b, expected %0b 0",
                             g, n, w_rdy, l_rdy, n == RD_LAT + 1);
                end
            end
            if (win) ref_b_rdata = ref_rd(32'h200);
            else     ref_a_rdata = ref_rd(32'h100);
            checks++;
            if ((win ? b_rdata : a_rdata) !== (win ? ref_b_rdata : ref_a_rdata)) begin
                errors++;
                $display("FAIL rr_rdata: got %08h expected %08h", win ? b_rdata : a_rdata, win ? ref_b_rdata : ref_a_rdata);
            end
            @(posedge clk); #1;
            checks++;
            if (ram_ce_b !== 1'b1 || a_rdy !== 1'b0 || b_rdy !== 1'b0) begin
                errors++;
                $display("FAIL rr_done: ce_b=%0b rdy=%0b%0b, expected 1 00", ram_ce_b, a_rdy, b_rdy);
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic test_read();
        preload(32'h10, 32'h12345678);
        do_txn(1'b0, 1'b0, 4'hF, 19'h00010, 32'h0, 1'b0);
        checks++;
        if (a_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL read_value: a_rdata=%08h expected 12345678", a_rdata);
        end
    endtask

    task automatic test_write();
        do_txn(1'b1, 1'b1, 4'hF, 19'h7FFFF, 32'hCAFEF00D, 1'b0);
        checks++;
        if (sram_rd(32'h7FFFF) !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL write_value: mem=%08h expected cafef00d", sram_rd(32'h7FFFF));
        end
    endtask

    task automatic test_rmw();
        preload(32'h20, 32'h11223344);
        do_txn(1'b0, 1'b1, 4'b0100, 19'h00020, 32'h00AB0000, 1'b1);
        checks++;
        if (sram_rd(32'h20) !== 32'h11AB3344) begin
            errors++;
            $display("FAIL rmw_value: mem=%08h expected 11ab3344", sram_rd(32'h20));
        end
        preload(32'h30, 32'hDEADBEEF);
        do_txn(1'b1, 1'b1, 4'b0000, 19'h00030, 32'h01234567, 1'b0);
        checks++;
        if (sram_rd(32'h30) !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rmw_be0: mem=%08h expected deadbeef", sram_rd(32'h30));
        end
    endtask

    task automatic test_random();
        bit          pb, we, drop;
        logic [3:0]  be;
        logic [18:0] addr;
        int          sel;
        for (int t = 0; t < 40; t++) begin
            pb   = 1'($urandom);
            we   = 1'($urandom);
            drop = 1'($urandom);
            sel  = $urandom_range(0, 3);
            be   = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
            addr = 19'h00300 + 19'($urandom_range(0, 15));
            do_txn(pb, we, be, addr, $urandom, drop);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        set_port(1'b1, 1'b1, 1'b1, 4'hF, 19'h01234, 32'hA5A5C3C3);
        set_port(1'b0, 1'b0, 1'b0, 4'h0, 19'h0, 32'h0);
        @(posedge clk); #1;
        b_req = 1'b0;
        refm[32'h1234] = 32'hA5A5C3C3;
        @(posedge clk); #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (ram_ce_b !== 1 || ram_oe_b !== 1 || ram_we_b !== 1 || ram_dout_oe !== 0 || b_rdy !== 0) begin
            errors++;
            $display("FAIL async_reset: ce=%0b oe=%0b we=%0b doe=%0b b_rdy=%0b, expected 1 1 1 0 0",
                     ram_ce_b, ram_oe_b, ram_we_b, ram_dout_oe, b_rdy);
        end
        last_b = 1'b0;
        ref_a_rdata = 32'h0;
        ref_b_rdata = 32'h0;
        set_port(1'b0, 1'b1, 1'b0, 4'hF, 19'h00010, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (ram_ce_b !== 1'b1 || b_rdy !== 1'b0 || a_rdy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: ce_b=%0b rdy=%0b%0b, expected 1 00", ram_ce_b, a_rdy, b_rdy);
            end
        end
        rst_b = 1'b1;
        do_txn(1'b0, 1'b0, 4'hF, 19'h00010, 32'h0, 1'b0);
    endtask

    task automatic test_memory_final();
        foreach (refm[k]) begin
            checks++;
            if (sram_rd(k) !== refm[k]) begin
                errors++;
                $display("FAIL mem_image: addr %05h got %08h expected %08h", k, sram_rd(k), refm[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read();
        test_write();
        test_rmw();
        test_random();
        test_reset_mid_write();
        test_memory_final();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
